tlb_pipe: RTL and testbench

//  Parametrised fully-associative LoongArch32 TLB, successor to the combinational 16-entry TLB.
//  Two registered search ports: port 0 for IF, port 1 for EX/MEM. One write port, one read port.

---
 rtl/tlb_pipe_pkg.sv | 45 ++++
 rtl/tlb_match_enc.sv | 20 ++
 rtl/tlb_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_tlb_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pipe_pkg.sv
// Shared TLB definitions: field widths, page sizes, INVTLB op codes, entry layout.
package tlb_pipe_pkg;
  localparam int VPPN_W = 19;
  localparam int PPN_W  = 20;
  localparam int ASID_W = 10;
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd22;

  typedef enum logic [4:0] {
    INV_ALL0 = 5'd0, INV_ALL1 = 5'd1, INV_G = 5'd2, INV_NG = 5'd3,
    INV_ASID = 5'd4, INV_ASID_VA = 5'd5, INV_GA_VA = 5'd6
  } inv_op_e;

  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic [1:0]       plv;
    logic [1:0]       mat;
    logic             d;
    logic             v;
  } page_t;

  typedef struct packed {
    logic [VPPN_W-1:0] vppn;
    logic              ps4m;
    logic [ASID_W-1:0] asid;
    logic              g;
    page_t             pg1;
    page_t             pg0;
  } entry_t;

  // A 4MB entry only compares VPPN[18:10]; the low bits live inside the page.
  function automatic logic va_hit(entry_t t, logic [VPPN_W-1:0] vppn);
    return (t.vppn[18:10] == vppn[18:10]) && (t.ps4m || (t.vppn[9:0] == vppn[9:0]));
  endfunction

  // Feedback tap masks for shift-left Fibonacci LFSRs of width 3..6.
  function automatic logic [5:0] lfsr_taps(int w);
    case (w)
      3:       return 6'b000110;
      4:       return 6'b001100;
      5:       return 6'b010100;
      default: return 6'b110000;
    endcase
  endfunction
endpackage

// File: rtl/tlb_match_enc.sv
// Match vector reduction: any hit, more-than-one hit, lowest hitting index.
module tlb_match_enc #(
  parameter int N    = 16,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    match,
  output logic            found,
  output logic            multi,
  output logic [IDXW-1:0] index
);
  assign found = |match;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(match & (match - N'(1)));

  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--)
      if (match[i]) index = IDXW'(i);
  end
endmodule

// File: rtl/tlb_pipe.sv
// Fully-associative LoongArch32 TLB: two registered search ports, write/read ports,
// INVTLB with illegal-op flag, and an LFSR fill index for TLBFILL.
module tlb_pipe
  import tlb_pipe_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s0_req,
  input  logic [18:0]       s0_vppn,
  input  logic              s0_va_bit12,
  input  logic [9:0]        s0_asid,
  output logic              s0_rvalid,
  output logic              s0_found,
  output logic              s0_multi,
  output logic [IDXW-1:0]   s0_index,
  output logic [19:0]       s0_ppn,
  output logic [5:0]        s0_ps,
  output logic [1:0]        s0_plv,
  output logic [1:0]        s0_mat,
  output logic              s0_d,
  output logic              s0_v,
  input  logic              s1_req,
  input  logic [18:0]       s1_vppn,
  input  logic              s1_va_bit12,
  input  logic [9:0]        s1_asid,
  output logic              s1_rvalid,
  output logic              s1_found,
  output logic              s1_multi,
  output logic [IDXW-1:0]   s1_index,
  output logic [19:0]       s1_ppn,
  output logic [5:0]        s1_ps,
  output logic [1:0]        s1_plv,
  output logic [1:0]        s1_mat,
  output logic              s1_d,
  output logic              s1_v,
  input  logic              we,
  input  logic [IDXW-1:0]   w_index,
  input  logic              w_e,
  input  logic [18:0]       w_vppn,
  input  logic [5:0]        w_ps,
  input  logic [9:0]        w_asid,
  input  logic              w_g,
  input  logic [19:0]       w_ppn0,
  input  logic [1:0]        w_plv0,
  input  logic [1:0]        w_mat0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [19:0]       w_ppn1,
  input  logic [1:0]        w_plv1,
  input  logic [1:0]        w_mat1,
  input  logic              w_d1,
  input  logic              w_v1,
  input  logic [IDXW-1:0]   r_index,
  output logic              r_e,
  output logic [18:0]       r_vppn,
  output logic [5:0]        r_ps,
  output logic [9:0]        r_asid,
  output logic              r_g,
  output logic [19:0]       r_ppn0,
  output logic [1:0]        r_plv0,
  output logic [1:0]        r_mat0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [19:0]       r_ppn1,
  output logic [1:0]        r_plv1,
  output logic [1:0]        r_mat1,
  output logic              r_d1,
  output logic              r_v1,
  input  logic              inv_valid,
  input  logic [4:0]        inv_op,
  input  logic [9:0]        inv_asid,
  input  logic [18:0]       inv_vppn,
  output logic              inv_bad,
  output logic [IDXW-1:0]   fill_index
);
  logic [TLBNUM-1:0] e_q;
  entry_t            tlb_q [TLBNUM];
  entry_t            w_ent;
  logic [TLBNUM-1:0] inv_hit;
  logic [IDXW-1:0]   fill_nx;

  assign w_ent = '{vppn: w_vppn, ps4m: (w_ps == PS_4M), asid: w_asid, g: w_g,
                   pg1: '{w_ppn1, w_plv1, w_mat1, w_d1, w_v1},
                   pg0: '{w_ppn0, w_plv0, w_mat0, w_d0, w_v0}};

  always_comb begin
    inv_hit = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (inv_op)
        INV_ALL0, INV_ALL1: inv_hit[i] = 1'b1;
        INV_G:       inv_hit[i] = tlb_q[i].g;
        INV_NG:      inv_hit[i] = !tlb_q[i].g;
        INV_ASID:    inv_hit[i] = !tlb_q[i].g && (tlb_q[i].asid == inv_asid);
        INV_ASID_VA: inv_hit[i] = !tlb_q[i].g && (tlb_q[i].asid == inv_asid) && va_hit(tlb_q[i], inv_vppn);
        INV_GA_VA:   inv_hit[i] = (tlb_q[i].g || (tlb_q[i].asid == inv_asid)) && va_hit(tlb_q[i], inv_vppn);
        default:     inv_hit[i] = 1'b0;
      endcase
    end
  end

  // Invalidate first, then the write to w_index overrides its own E bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q     <= '0;
      inv_bad <= 1'b0;
    end else begin
      for (int i = 0; i < TLBNUM; i++)
        if (inv_valid && inv_hit[i]) e_q[i] <= 1'b0;
      if (we) e_q[w_index] <= w_e;
      inv_bad <= inv_valid && (inv_op > 5'd6);
    end
  end

  always_ff @(posedge clk)
    if (we) tlb_q[w_index] <= w_ent;

  if (IDXW == 2) begin : g_fill_cnt
    assign fill_nx = fill_index + IDXW'(1);
  end else begin : g_fill_lfsr
    localparam logic [IDXW-1:0] TAPS = IDXW'(lfsr_taps(IDXW));
    assign fill_nx = {fill_index[IDXW-2:0], ^(fill_index & TAPS)};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  fill_index <= IDXW'(1);
    else if (we)  fill_index <= fill_nx;
  end

  logic [1:0]                    s_req, s_b12;
  logic [1:0][VPPN_W-1:0]        s_vppn;
  logic [1:0][ASID_W-1:0]        s_asid;
  logic [1:0]                    rv_a, fd_a, mu_a;
  logic [1:0][IDXW-1:0]          ix_a;
  logic [1:0][5:0]               ps_a;
  page_t [1:0]                   pg_a;

  assign s_req  = {s1_req, s0_req};
  assign s_b12  = {s1_va_bit12, s0_va_bit12};
  assign s_vppn = {s1_vppn, s0_vppn};
  assign s_asid = {s1_asid, s0_asid};

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [TLBNUM-1:0] match;
    logic              hit, mul, odd;
    logic [IDXW-1:0]   idx;
    logic              rv_q, fd_q, mu_q;
    logic [IDXW-1:0]   ix_q;
    logic [5:0]        ps_q;
    page_t             pg_q;

    always_comb begin
      match = '0;
      for (int i = 0; i < TLBNUM; i++)
        match[i] = e_q[i] && va_hit(tlb_q[i], s_vppn[p]) &&
                   (tlb_q[i].g || (tlb_q[i].asid == s_asid[p]));
    end

    tlb_match_enc #(.N(TLBNUM), .IDXW(IDXW)) u_enc (
      .match(match), .found(hit), .multi(mul), .index(idx)
    );

    assign odd = tlb_q[idx].ps4m ? s_vppn[p][9] : s_b12[p];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rv_q <= 1'b0; fd_q <= 1'b0; mu_q <= 1'b0;
        ix_q <= '0;   ps_q <= '0;   pg_q <= '0;
      end else begin
        rv_q <= s_req[p];
        if (s_req[p]) begin
          fd_q <= hit;
          mu_q <= mul;
          ix_q <= hit ? idx : '0;
          ps_q <= !hit ? 6'd0 : (tlb_q[idx].ps4m ? PS_4M : PS_4K);
          pg_q <= !hit ? '0 : (odd ? tlb_q[idx].pg1 : tlb_q[idx].pg0);
        end
      end
    end

    assign rv_a[p] = rv_q;
    assign fd_a[p] = fd_q;
    assign mu_a[p] = mu_q;
    assign ix_a[p] = ix_q;
    assign ps_a[p] = ps_q;
    assign pg_a[p] = pg_q;
  end

  assign {s1_rvalid, s0_rvalid} = rv_a;
  assign {s1_found,  s0_found}  = fd_a;
  assign {s1_multi,  s0_multi}  = mu_a;
  assign s0_index = ix_a[0];
  assign s1_index = ix_a[1];
  assign s0_ps    = ps_a[0];
  assign s1_ps    = ps_a[1];
  assign {s0_ppn, s0_plv, s0_mat, s0_d, s0_v} = pg_a[0];
  assign {s1_ppn, s1_plv, s1_mat, s1_d, s1_v} = pg_a[1];

  assign r_e    = e_q[r_index];
  assign r_vppn = tlb_q[r_index].vppn;
  assign r_ps   = tlb_q[r_index].ps4m ? PS_4M : PS_4K;
  assign r_asid = tlb_q[r_index].asid;
  assign r_g    = tlb_q[r_index].g;
  assign {r_ppn0, r_plv0, r_mat0, r_d0, r_v0} = tlb_q[r_index].pg0;
  assign {r_ppn1, r_plv1, r_mat1, r_d1, r_v1} = tlb_q[r_index].pg1;
endmodule

// File: tb/tb_tlb_pipe.sv
// Random + directed bench for tlb_pipe; search results checked by a queue scoreboard.
module tb_tlb_pipe;
  logic clk = 1'b0, resetn = 1'b0;
  logic s0_req = 0, s0_va_bit12 = 0, s1_req = 0, s1_va_bit12 = 0;
  logic [18:0] s0_vppn = 0, s1_vppn = 0;
  logic [9:0] s0_asid = 0, s1_asid = 0;
  logic s0_rvalid, s0_found, s0_multi, s0_d, s0_v, s1_rvalid, s1_found, s1_multi, s1_d, s1_v;
  logic [3:0] s0_index, s1_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0] s0_ps, s1_ps;
  logic [1:0] s0_plv, s0_mat, s1_plv, s1_mat;
  logic we = 0, w_e = 0, w_g = 0, w_d0 = 0, w_v0 = 0, w_d1 = 0, w_v1 = 0;
  logic [3:0] w_index = 0, r_index = 0;
  logic [18:0] w_vppn = 0;
  logic [5:0] w_ps = 0;
  logic [9:0] w_asid = 0;
  logic [19:0] w_ppn0 = 0, w_ppn1 = 0;
  logic [1:0] w_plv0 = 0, w_mat0 = 0, w_plv1 = 0, w_mat1 = 0;
  logic r_e, r_g, r_d0, r_v0, r_d1, r_v1;
  logic [18:0] r_vppn;
  logic [5:0] r_ps;
  logic [9:0] r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0] r_plv0, r_mat0, r_plv1, r_mat1;
  logic inv_valid = 0, inv_bad;
  logic [4:0] inv_op = 0;
  logic [9:0] inv_asid = 0;
  logic [18:0] inv_vppn = 0;
  logic [3:0] fill_index;

  tlb_pipe #(.TLBNUM(16)) dut (
    .clk(clk), .resetn(resetn),
    .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_rvalid(s0_rvalid), .s0_found(s0_found), .s0_multi(s0_multi), .s0_index(s0_index),
    .s0_ppn(s0_ppn), .s0_ps(s0_ps), .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
    .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_rvalid(s1_rvalid), .s1_found(s1_found), .s1_multi(s1_multi), .s1_index(s1_index),
    .s1_ppn(s1_ppn), .s1_ps(s1_ps), .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid),
    .w_g(w_g), .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_bad(inv_bad), .fill_index(fill_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit e; bit wr; logic [18:0] vppn; int ps; logic [9:0] asid; bit g;
    logic [1:0][19:0] ppn; logic [1:0][1:0] plv; logic [1:0][1:0] mat; logic [1:0] d; logic [1:0] v;
  } ment_t;

  ment_t m [16];
  logic [37:0] q0 [$];
  logic [37:0] q1 [$];
  int total = 0, bad = 0;
  logic [18:0] pool [8] = '{19'h00100, 19'h00101, 19'h00500, 19'h40000,
                            19'h403FF, 19'h12345, 19'h00300, 19'h7FFFF};

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Same-pair check: VA and entry agree on every bit above the page-pair boundary.
  function automatic bit same_pair(logic [18:0] a, logic [18:0] b, int ps);
    logic [31:0] va = {a, 13'h0};
    logic [31:0] vb = {b, 13'h0};
    return (va >> (ps + 1)) == (vb >> (ps + 1));
  endfunction

  function automatic logic [37:0] exp_search(logic [18:0] vppn, logic b12, logic [9:0] asid);
    logic [31:0] va = {vppn, b12, 12'h0};
    int cnt = 0;
    logic [37:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      if (!m[i].e || !same_pair(vppn, m[i].vppn, m[i].ps)) continue;
      if (!m[i].g && m[i].asid != asid) continue;
      cnt++;
      if (cnt == 1) begin
        int k = va[m[i].ps] ? 1 : 0;
        r = {1'b1, 1'b0, 4'(i), m[i].ppn[k], 6'(m[i].ps), m[i].plv[k], m[i].mat[k], m[i].d[k], m[i].v[k]};
      end
    end
    r[36] = (cnt > 1);
    return r;
  endfunction

  function automatic bit inv_cond(int i);
    bit vam = same_pair(inv_vppn, m[i].vppn, m[i].ps);
    bit am  = (m[i].asid == inv_asid);
    case (inv_op)
      0, 1: return 1;
      2: return m[i].g;
      3: return !m[i].g;
      4: return !m[i].g && am;
      5: return !m[i].g && am && vam;
      6: return (m[i].g || am) && vam;
      default: return 0;
    endcase
  endfunction

  // Apply one clock of stimulus: record expectations, advance the model, clock, clear strobes.
  task automatic tick();
    bit exp_bad;
    if (s0_req) q0.push_back(exp_search(s0_vppn, s0_va_bit12, s0_asid));
    if (s1_req) q1.push_back(exp_search(s1_vppn, s1_va_bit12, s1_asid));
    if (inv_valid)
      for (int i = 0; i < 16; i++) if (inv_cond(i)) m[i].e = 0;
    if (we) begin
      int i = int'(w_index);
      m[i].e = w_e; m[i].wr = 1; m[i].vppn = w_vppn; m[i].ps = (w_ps == 6'd22) ? 22 : 12;
      m[i].asid = w_asid; m[i].g = w_g;
      m[i].ppn = {w_ppn1, w_ppn0}; m[i].plv = {w_plv1, w_plv0}; m[i].mat = {w_mat1, w_mat0};
      m[i].d = {w_d1, w_d0}; m[i].v = {w_v1, w_v0};
    end
    exp_bad = inv_valid && (inv_op > 5'd6);
    @(posedge clk); #1;
    chk("inv_bad", 64'(inv_bad), 64'(exp_bad));
    s0_req = 0; s1_req = 0; we = 0; inv_valid = 0;
  endtask

  task automatic setw(int idx, bit e, logic [18:0] vppn, int ps, logic [9:0] asid, bit g,
                      logic [19:0] p0, logic [19:0] p1);
    we = 1; w_index = 4'(idx); w_e = e; w_vppn = vppn; w_ps = 6'(ps); w_asid = asid; w_g = g;
    w_ppn0 = p0; w_ppn1 = p1;
    {w_plv0, w_mat0, w_d0, w_v0} = 6'($urandom); {w_plv1, w_mat1, w_d1, w_v1} = 6'($urandom);
  endtask

  task automatic search(int p, logic [18:0] vppn, logic b12, logic [9:0] asid);
    if (p == 0) begin s0_req = 1; s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid; end
    else        begin s1_req = 1; s1_vppn = vppn; s1_va_bit12 = b12; s1_asid = asid; end
  endtask

  task automatic inv(int op, logic [9:0] asid, logic [18:0] vppn);
    inv_valid = 1; inv_op = 5'(op); inv_asid = asid; inv_vppn = vppn;
  endtask

  task automatic chk_rd(int idx);
    r_index = 4'(idx); #1;
    chk("r_e", 64'(r_e), 64'(m[idx].e));
    if (m[idx].wr)
      chk("r_fields", {r_vppn, r_ps, r_asid, r_g, r_ppn1[8:0]},
          {m[idx].vppn, 6'(m[idx].ps), m[idx].asid, m[idx].g, m[idx].ppn[1][8:0]});
    if (m[idx].wr)
      chk("r_page", {r_ppn0, r_plv0, r_mat0, r_d0, r_v0, r_plv1, r_mat1, r_d1, r_v1},
          {m[idx].ppn[0], m[idx].plv[0], m[idx].mat[0], m[idx].d[0], m[idx].v[0],
           m[idx].plv[1], m[idx].mat[1], m[idx].d[1], m[idx].v[1]});
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (s0_rvalid) begin
        if (q0.size() == 0) chk("s0_unexpected", 64'(1), 64'(0));
        else chk("s0_result", 64'({s0_found, s0_multi, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v}),
                 64'(q0.pop_front()));
      end
      if (s1_rvalid) begin
        if (q1.size() == 0) chk("s1_unexpected", 64'(1), 64'(0));
        else chk("s1_result", 64'({s1_found, s1_multi, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v}),
                 64'(q1.pop_front()));
      end
    end
  end

  initial begin
    logic [3:0] prev;
    bit [15:0] seen;
    for (int i = 0; i < 16; i++) begin m[i] = '{default: '0}; m[i].ps = 12; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {s0_rvalid, s0_found, s0_multi, s1_rvalid, s1_found, s1_multi, inv_bad}, 0);
    chk("rst_search_fields", {s0_index, s0_ppn, s0_ps, s1_index, s1_ppn, s1_ps}, 0);
    chk("rst_fill", 64'(fill_index), 64'(1));
    resetn = 1;
    // Empty TLB: any search misses.
    search(0, 19'h12345, 1, 10'd5); tick();
    // 4KB entry, odd page, ASID-sensitive.
    setw(3, 1, 19'h12345, 12, 10'd5, 0, 20'hAAAAA, 20'hBBBBB); tick();
    search(1, 19'h12345, 1, 10'd5); tick();
    chk("t2_index", 64'(s1_index), 64'(3));
    chk("t2_ppn", 64'({s1_found, s1_ppn, s1_ps}), 64'({1'b1, 20'hBBBBB, 6'd12}));
    search(1, 19'h12345, 1, 10'd6); tick();
    chk("t2_asid_miss", 64'(s1_found), 64'(0));
    // Global 4MB entry: low VPPN bits ignored, VPPN[9] picks the odd page.
    setw(7, 1, 19'h40000, 22, 10'd0, 1, 20'h11111, 20'h00400); tick();
    search(0, 19'h403FF, 0, 10'd9); tick();
    chk("t3_hit", 64'({s0_found, s0_index, s0_ppn, s0_ps}), 64'({1'b1, 4'd7, 20'h00400, 6'd22}));
    // Duplicates: lowest index reported with multi set.
    setw(2, 1, 19'h00300, 12, 10'd1, 1, 20'h22222, 20'h33333); tick();
    setw(9, 1, 19'h00300, 12, 10'd1, 1, 20'h22222, 20'h33333); tick();
    search(0, 19'h00300, 0, 10'd4); search(1, 19'h00300, 1, 10'd4); tick();
    chk("t4_multi", 64'({s0_index, s0_multi}), 64'({4'd2, 1'b1}));
    // INVTLB selectivity.
    setw(10, 1, 19'h00500, 12, 10'd5, 1, 20'h1, 20'h2); tick();
    setw(11, 1, 19'h00501, 12, 10'd5, 0, 20'h3, 20'h4); tick();
    setw(12, 1, 19'h00502, 12, 10'd6, 0, 20'h5, 20'h6); tick();
    inv(4, 10'd5, 19'h0); tick();
    chk_rd(10); chk_rd(11); chk_rd(12);
    chk("t5_op4", 64'({m[10].e, m[11].e, m[12].e}), 64'(3'b101));
    inv(2, 10'd0, 19'h0); tick();
    chk_rd(10);
    inv(9, 10'd6, 19'h00502); tick();
    chk_rd(12);
    chk("t5_op9_keep", 64'(r_e), 64'(1));
    // Invalidate-all racing a write: only the written entry survives.
    inv(0, 10'd0, 19'h0); setw(1, 1, 19'h00100, 12, 10'd2, 0, 20'h7, 20'h8); tick();
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i); #1;
      chk("t6_only_idx1", 64'(r_e), 64'(i == 1));
    end
    // Fill index: every we cycle steps a 15-state sequence; idle cycles hold.
    prev = fill_index; seen = '0;
    for (int k = 0; k < 15; k++) begin
      setw($urandom_range(0, 15), $urandom_range(0, 1), pool[$urandom_range(0, 7)], 12,
           10'($urandom_range(0, 3)), $urandom_range(0, 1), 20'($urandom), 20'($urandom));
      tick();
      chk("fill_step", 64'(fill_index != prev && fill_index != 0), 64'(1));
      seen[fill_index] = 1; prev = fill_index;
    end
    chk("fill_period", 64'($countones(seen)), 64'(15));
    tick();
    chk("fill_hold", 64'(fill_index), 64'(prev));
    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int ps_sel = $urandom_range(0, 2);
        setw($urandom_range(0, 15), $urandom_range(0, 4) != 0,
             pool[$urandom_range(0, 7)] ^ 19'($urandom_range(0, 1)),
             ps_sel == 0 ? 12 : (ps_sel == 1 ? 22 : 13),
             10'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, 20'($urandom), 20'($urandom));
      end
      if ($urandom_range(0, 7) == 0)
        inv($urandom_range(0, 7) == 0 ? 0 : $urandom_range(2, 9), 10'($urandom_range(0, 3)),
            pool[$urandom_range(0, 7)]);
      if ($urandom_range(0, 3) != 0)
        search(0, pool[$urandom_range(0, 7)], 1'($urandom), 10'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) != 0)
        search(1, pool[$urandom_range(0, 7)], 1'($urandom), 10'($urandom_range(0, 3)));
      tick();
      chk_rd($urandom_range(0, 15));
    end
    // Reset asserted while a search result is being presented.
    search(0, 19'h00100, 0, 10'd2); tick();
    #1 resetn = 0;
    #1;
    q0.delete();
    for (int i = 0; i < 16; i++) m[i].e = 0;
    chk("rst_mid_rvalid", 64'({s0_rvalid, s0_found}), 64'(0));
    for (int i = 0; i < 16; i++) begin
      r_index = 4'(i); #1;
      chk("rst_mid_e", 64'(r_e), 64'(0));
    end
    @(negedge clk); resetn = 1;
    chk("rst_mid_fill", 64'(fill_index), 64'(1));
    search(1, 19'h00100, 0, 10'd2); tick();
    repeat (3) tick();
    chk("q0_drained", 64'(q0.size()), 64'(0));
    chk("q1_drained", 64'(q1.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
